// File: rtl/adder_unit.sv
// -----------------------------------------------------------------------------
// adder_unit
//   Registered unsigned adder. It adds two WIDTH-bit operands and returns the
//   full (WIDTH+1)-bit sum. The MSB of the sum is the carry-out, so the result
//   never overflows. The sum is built from a generated ripple-carry chain of
//   full-adder cells.
//
// Build option:
//   ADDER_PIPE_EN - when defined, the adder is split into two registered
//                   stages. The low half and the upper half are added in
//                   separate cycles, so latency becomes 2 cycles.
//                   Throughput stays at one pair per cycle. WIDTH must be even.
//                   When undefined, the block has a single stage with
//                   latency 1.
//
// Parameters:
//   WIDTH     - operand width in bits, 2..32 (even when ADDER_PIPE_EN is
//               defined).
//
// Ports:
//   clk       - rising-edge clock, the only clock of the block.
//   rst       - synchronous active-high reset. Clears the result and valid.
//   a, b      - unsigned operands.
//   out       - registered sum a+b. Bit WIDTH is the carry-out.
//   out_valid - high when out holds a sum of operands sampled after reset
//               was released.
// -----------------------------------------------------------------------------
module adder_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   out,
  output logic             out_valid
);

  logic [WIDTH:0] out_d, out_q;
  logic           valid_d, valid_q;

`ifdef ADDER_PIPE_EN
  localparam int HALF = WIDTH / 2;
  localparam int HI   = WIDTH - HALF;

  // ---------------- Stage 1: low-half ripple chain ----------------
  logic [HALF:0]   c_lo_s;
  logic [HALF-1:0] s_lo_s;

  assign c_lo_s[0] = 1'b0;

  for (genvar i = 0; i < HALF; i++) begin : g_lo_cell
    assign s_lo_s[i]   = a[i] ^ b[i] ^ c_lo_s[i];
    assign c_lo_s[i+1] = (a[i] & b[i]) | (c_lo_s[i] & (a[i] ^ b[i]));
  end

  // The upper operand halves travel with the low sum so that stage 2 sees
  // a matched set of values.
  logic [HALF-1:0] lo_sum_d, lo_sum_q;
  logic            mid_c_d, mid_c_q;
  logic [HI-1:0]   a_hi_d, a_hi_q;
  logic [HI-1:0]   b_hi_d, b_hi_q;
  logic            v1_d, v1_q;

  // Stage 1 next-state: capture the low sum, the mid carry and the upper halves.
  always_comb begin
    lo_sum_d = {HALF{1'b0}};
    mid_c_d  = 1'b0;
    a_hi_d   = {HI{1'b0}};
    b_hi_d   = {HI{1'b0}};
    v1_d     = 1'b0;
    if (rst) begin
      lo_sum_d = {HALF{1'b0}};
      mid_c_d  = 1'b0;
      a_hi_d   = {HI{1'b0}};
      b_hi_d   = {HI{1'b0}};
      v1_d     = 1'b0;
    end else begin
      lo_sum_d = s_lo_s;
      mid_c_d  = c_lo_s[HALF];
      a_hi_d   = a[WIDTH-1:HALF];
      b_hi_d   = b[WIDTH-1:HALF];
      v1_d     = 1'b1;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    lo_sum_q <= lo_sum_d;
    mid_c_q  <= mid_c_d;
    a_hi_q   <= a_hi_d;
    b_hi_q   <= b_hi_d;
    v1_q     <= v1_d;
  end

  // ---------------- Stage 2: upper-half ripple chain ----------------
  logic [HI:0]   c_hi_s;
  logic [HI-1:0] s_hi_s;

  // The registered mid carry enters the upper chain as its carry-in.
  assign c_hi_s[0] = mid_c_q;

  for (genvar j = 0; j < HI; j++) begin : g_hi_cell
    assign s_hi_s[j]   = a_hi_q[j] ^ b_hi_q[j] ^ c_hi_s[j];
    assign c_hi_s[j+1] = (a_hi_q[j] & b_hi_q[j]) | (c_hi_s[j] & (a_hi_q[j] ^ b_hi_q[j]));
  end

  // Stage 2 next-state: join the two halves into the full result.
  always_comb begin
    out_d   = {(WIDTH+1){1'b0}};
    valid_d = 1'b0;
    if (rst) begin
      out_d   = {(WIDTH+1){1'b0}};
      valid_d = 1'b0;
    end else begin
      out_d   = {c_hi_s[HI], s_hi_s, lo_sum_q};
      valid_d = v1_q;
    end
  end
`else
  // ---------------- Single stage: full-width ripple chain ----------------
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] s_s;

  assign c_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s_s[i]   = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  // Output next-state: reset overrides the add. Otherwise valid is set for good.
  always_comb begin
    out_d   = {(WIDTH+1){1'b0}};
    valid_d = 1'b0;
    if (rst) begin
      out_d   = {(WIDTH+1){1'b0}};
      valid_d = 1'b0;
    end else begin
      out_d   = {c_s[WIDTH], s_s};
      valid_d = 1'b1;
    end
  end
`endif

  // Output registers.
  always_ff @(posedge clk) begin
    out_q   <= out_d;
    valid_q <= valid_d;
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_adder_unit
//   Directed and random-class stimulus for adder_unit with WIDTH=4.
//   Each step drives one operand pair and the reset level, then waits for one
//   clock edge. After the edge it checks out and out_valid against the
//   expected values. Each step also supplies the expected sum for its pair.
//   A two-entry history delays that sum by the latency of the build.
// -----------------------------------------------------------------------------
module tb_adder_unit;

`ifdef ADDER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] out_s;
  logic       out_valid_s;

  int n_assert;
  int n_fail;

  // History of the last two edges. Index 0 is the most recent edge.
  int sum_h [2];
  bit rst_h [2];

  adder_unit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .out       (out_s),
    .out_valid (out_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] ai, input logic [3:0] bi, input bit ri,
                      input int exp_sum, input string tag);
    logic [4:0] e_out;
    logic       e_v;
    bit         any_rst;
    int         src;
    a = ai;
    b = bi;
    rst = ri;
    sum_h[1] = sum_h[0];
    rst_h[1] = rst_h[0];
    sum_h[0] = exp_sum;
    rst_h[0] = ri;
    @(posedge clk);
    #1;
    // A reset on any edge still inside the pipeline clears the result.
    any_rst = (LAT == 1) ? rst_h[0] : (rst_h[0] | rst_h[1]);
    src     = (LAT == 1) ? sum_h[0] : sum_h[1];
    e_out   = any_rst ? 5'd0 : src[4:0];
    e_v     = ~any_rst;
    n_assert++;
    assert (out_s === e_out) else begin
      n_fail++;
      $error("FAIL %s out: observed %0d expected %0d", tag, out_s, e_out);
    end
    n_assert++;
    assert (out_valid_s === e_v) else begin
      n_fail++;
      $error("FAIL %s out_valid: observed %0b expected %0b", tag, out_valid_s, e_v);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] q;
    n_assert = 0;
    n_fail   = 0;
    sum_h[0] = 0;
    sum_h[1] = 0;
    rst_h[0] = 1'b1;
    rst_h[1] = 1'b1;
    a   = 4'd0;
    b   = 4'd0;
    rst = 1'b1;

    // Reset held for two cycles with 9+9 on the inputs.
    step(4'd9, 4'd9, 1'b1, 18, "reset_hold0");
    step(4'd9, 4'd9, 1'b1, 18, "reset_hold1");
    // Release reset. 18 appears after LAT edges.
    step(4'd9, 4'd9, 1'b0, 18, "release0");
    step(4'd9, 4'd9, 1'b0, 18, "release1");

    // Boundary cases.
    step(4'd0,  4'd0,  1'b0, 0,  "zero_zero");
    step(4'd15, 4'd15, 1'b0, 30, "max_max");
    step(4'd15, 4'd1,  1'b0, 16, "max_plus_one");
    step(4'd1,  4'd15, 1'b0, 16, "one_plus_max");
    step(4'd1,  4'd15, 1'b0, 16, "one_plus_max_hold");
    step(4'd6,  4'd5,  1'b0, 11, "six_five");
    step(4'd8,  4'd8,  1'b0, 16, "eight_eight");

    // Random classes.
    for (int i = 0; i < 100; i++) begin
      r = 4'($urandom_range(0, 15));
      q = 4'($urandom_range(0, 15));
      step(r, q, 1'b0, int'(r) + int'(q), "rand_both");
    end
    for (int i = 0; i < 100; i++) begin
      r = 4'($urandom_range(0, 15));
      step(r, 4'd0, 1'b0, int'(r), "rand_a_b0");
    end
    for (int i = 0; i < 100; i++) begin
      r = 4'($urandom_range(0, 15));
      step(4'd0, r, 1'b0, int'(r), "a0_rand_b");
    end
    for (int i = 0; i < 100; i++) begin
      r = 4'($urandom_range(0, 15));
      step(4'd15, r, 1'b0, 15 + int'(r), "a15_rand_b");
    end
    for (int i = 0; i < 100; i++) begin
      r = 4'($urandom_range(0, 15));
      step(r, 4'd15, 1'b0, int'(r) + 15, "rand_a_b15");
    end

    // Back-to-back stream with a one-cycle reset pulse between the pairs.
    // Expected output sequence: 7, then 0 with out_valid=0, then 30.
    step(4'd3,  4'd4,  1'b0, 7,  "stream_3_4");
    step(4'd3,  4'd4,  1'b0, 7,  "stream_3_4_hold");
    step(4'd3,  4'd4,  1'b1, 7,  "stream_rst_pulse");
    step(4'd15, 4'd15, 1'b0, 30, "stream_15_15");
    step(4'd15, 4'd15, 1'b0, 30, "stream_15_15_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_unit.md
Name: adder_unit

Overview:
- Registered unsigned adder: sums two WIDTH-bit operands and presents the full (WIDTH+1)-bit result, carry included, one clock later.
- Used as a pipelined arithmetic leaf inside datapath blocks.
- No overflow or truncation is possible because the MSB of the result is the carry-out.
- Internally a generated ripple-carry chain of full-adder cells, not a behavioural "+".

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; must be even when ADDER_PIPE_EN is defined.

Ports:
- clk  input  1  rising-edge clock, only clock of the block
- rst  input  1  synchronous reset, active-high
- a  input  WIDTH  unsigned operand A
- b  input  WIDTH  unsigned operand B
- out  output  WIDTH+1  registered sum a+b; bit WIDTH is carry-out
- out_valid  output  1  high when out holds a sum of operands sampled after reset release

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst is sampled on posedge clk only, no asynchronous path.
  - rst high at an edge sets out=0 and out_valid=0, overriding the add.
- Datapath:
  - Combinational ripple-carry chain over bits 0..WIDTH-1, carry-in of bit 0 tied to 0.
  - sum_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | c_i&(a_i^b_i).
  - out[WIDTH] = c_WIDTH.
- Latency and throughput:
  - Latency 1: operands present before posedge N appear on out after posedge N.
  - New operands accepted every cycle, no handshake or stall.
  - out holds its value while a and b are unchanged. It is re-registered every cycle, so it always reflects the last sampled pair.
- Arithmetic:
  - Unsigned; out = a + b exactly, range 0..2^(WIDTH+1)-2 (0..30 for WIDTH=4).
  - No saturation or wrap.
- out_valid:
  - Goes 1 at the first edge with rst low whose sampled operands are real, i.e. the first edge after reset deasserts.
  - Stays 1 until the next reset.
  - Before any reset after power-up, out and out_valid are X or uninitialised. The bench must apply reset first.
- Boundary conditions:
  - 0+0 -> 0.
  - max+max -> 2^(WIDTH+1)-2 with carry set.
  - max+1 -> 2^WIDTH; carry ripples through every cell, which is the critical timing path.
  - Operand order is irrelevant.
- Reset mid-operation:
  - The result of the cycle where rst is high is discarded; out=0 and out_valid=0 on that edge.
  - Normal sums resume at the first edge with rst low.

Optional Feature:
- Macro: ADDER_PIPE_EN.
- When defined, the adder is split into two registered stages:
  - Stage 1 adds the low WIDTH/2 bits and registers the low sum, the mid carry and the upper operand halves.
  - Stage 2 adds the upper halves plus the registered carry and registers the full result.
- Effects when defined:
  - Latency becomes 2 cycles; throughput stays 1 per cycle.
  - out_valid asserts on the second edge after reset release.
  - Reset clears both stages.
- When undefined: single-stage behaviour described above, latency 1.
- Result values are identical in both modes; only the timing differs.

Test Plan:
- Reset held 2 cycles with a=9, b=9 -> out=0, out_valid=0; release -> after 1 edge out=18, out_valid=1.
- a=0,b=0 -> out=0.
- a=15,b=15 -> out=30 (5'b11110).
- a=15,b=1 -> out=16; then a=1,b=15 -> out=16 (full carry ripple both orders).
- 100 random pairs in each class, checked against a+b one cycle later (two with ADDER_PIPE_EN):
  - both operands random
  - a random, b=0 (out=a)
  - a=0, b random (out=b)
  - a=15, b random
  - a random, b=15
- Back-to-back stream a=3,b=4 then a=15,b=15, with rst pulsed high for the cycle between them -> out sequence 7, 0 (out_valid=0), 30.
